decode_stage: RTL and testbench

//  RV32I decode stage, directly downstream of fetch. Takes fetch's PC_out/IR_out,

---
 rtl/decode_stage.sv | 216 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage sitting directly behind fetch.
//
// Splits the fetched instruction into fields, builds the sign-extended
// immediate, flags unsupported opcodes and reads rs1/rs2 from a register
// file with a write-port bypass. Everything is captured in one pipeline
// register for the execute stage (latency 1). The pipeline register
// supports hold (stall) and squash (flush). Writeback into the register
// file is independent of stall/flush.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   PC_in, IR_in        PC and instruction word from fetch
//   valid_in            PC_in/IR_in carry a real instruction
//   stall, flush        hold / bubble the pipeline register (flush wins)
//   WB_en, WB_rd,
//   WB_data             register file write port (x0 writes ignored)
//   PC_out .. FUNCT7_b5 registered decode results
//   valid_out           registered outputs hold a real instruction
//   ILLEGAL_out         valid instruction with an unsupported opcode
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PC_in,
    input  logic [XLEN-1:0] IR_in,
    input  logic            valid_in,
    input  logic            stall,
    input  logic            flush,
    input  logic            WB_en,
    input  logic [4:0]      WB_rd,
    input  logic [XLEN-1:0] WB_data,
    output logic [XLEN-1:0] PC_out,
    output logic [XLEN-1:0] RS1_val,
    output logic [XLEN-1:0] RS2_val,
    output logic [XLEN-1:0] IMM_out,
    output logic [4:0]      RD_out,
    output logic [6:0]      OPCODE_out,
    output logic [2:0]      FUNCT3_out,
    output logic            FUNCT7_b5,
    output logic            valid_out,
    output logic            ILLEGAL_out
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // Entry 0 exists but is never written, so it always reads as zero.
    logic [XLEN-1:0] rf_q [NUM_REGS];

    logic [6:0]      opcode_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [XLEN-1:0] imm_s;
    logic            legal_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;

    logic [XLEN-1:0] pc_q,  pc_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rd_q,  rd_d;
    logic [6:0]      op_q,  op_d;
    logic [2:0]      f3_q,  f3_d;
    logic            f7b5_q, f7b5_d;
    logic            valid_q, valid_d;
    logic            illegal_q, illegal_d;

    assign opcode_s = IR_in[6:0];
    assign rs1_s    = IR_in[19:15];
    assign rs2_s    = IR_in[24:20];

    // Immediate generation and opcode legality.
    always_comb begin
        imm_s   = {XLEN{1'b0}};
        legal_s = 1'b1;
        case (opcode_s)
            OP_IMM, OP_LOAD, OP_JALR:
                imm_s = {{20{IR_in[31]}}, IR_in[31:20]};
            OP_STORE:
                imm_s = {{20{IR_in[31]}}, IR_in[31:25], IR_in[11:7]};
            OP_BRANCH:
                imm_s = {{19{IR_in[31]}}, IR_in[31], IR_in[7], IR_in[30:25],
                         IR_in[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_s = {IR_in[31:12], 12'h000};
            OP_JAL:
                imm_s = {{11{IR_in[31]}}, IR_in[31], IR_in[19:12], IR_in[20],
                         IR_in[30:21], 1'b0};
            OP_REG, OP_SYSTEM, OP_FENCE:
                imm_s = {XLEN{1'b0}};
            default:
                legal_s = 1'b0;
        endcase
    end

    // Register reads; a same-cycle writeback to the source wins over the array.
    always_comb begin
        if (rs1_s == 5'd0) begin
            rs1_val_s = {XLEN{1'b0}};
        end else if (WB_en && (WB_rd == rs1_s)) begin
            rs1_val_s = WB_data;
        end else begin
            rs1_val_s = rf_q[rs1_s];
        end
        if (rs2_s == 5'd0) begin
            rs2_val_s = {XLEN{1'b0}};
        end else if (WB_en && (WB_rd == rs2_s)) begin
            rs2_val_s = WB_data;
        end else begin
            rs2_val_s = rf_q[rs2_s];
        end
    end

    // Register file writeback, independent of stall/flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= {XLEN{1'b0}};
            end
        end else if (WB_en && (WB_rd != 5'd0)) begin
            rf_q[WB_rd] <= WB_data;
        end
    end

    // Next pipeline state: flush > stall > load; an invalid load is a bubble.
    always_comb begin
        pc_d      = {XLEN{1'b0}};
        rs1_d     = {XLEN{1'b0}};
        rs2_d     = {XLEN{1'b0}};
        imm_d     = {XLEN{1'b0}};
        rd_d      = 5'd0;
        op_d      = 7'd0;
        f3_d      = 3'd0;
        f7b5_d    = 1'b0;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
        end else if (stall) begin
            pc_d      = pc_q;
            rs1_d     = rs1_q;
            rs2_d     = rs2_q;
            imm_d     = imm_q;
            rd_d      = rd_q;
            op_d      = op_q;
            f3_d      = f3_q;
            f7b5_d    = f7b5_q;
            valid_d   = valid_q;
            illegal_d = illegal_q;
        end else if (valid_in) begin
            pc_d      = PC_in;
            rs1_d     = rs1_val_s;
            rs2_d     = rs2_val_s;
            imm_d     = imm_s;
            rd_d      = IR_in[11:7];
            op_d      = opcode_s;
            f3_d      = IR_in[14:12];
            f7b5_d    = IR_in[30];
            valid_d   = 1'b1;
            illegal_d = ~legal_s;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Decode/execute pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= {XLEN{1'b0}};
            rs1_q     <= {XLEN{1'b0}};
            rs2_q     <= {XLEN{1'b0}};
            imm_q     <= {XLEN{1'b0}};
            rd_q      <= 5'd0;
            op_q      <= 7'd0;
            f3_q      <= 3'd0;
            f7b5_q    <= 1'b0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            op_q      <= op_d;
            f3_q      <= f3_d;
            f7b5_q    <= f7b5_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign PC_out      = pc_q;
    assign RS1_val     = rs1_q;
    assign RS2_val     = rs2_q;
    assign IMM_out     = imm_q;
    assign RD_out      = rd_q;
    assign OPCODE_out  = op_q;
    assign FUNCT3_out  = f3_q;
    assign FUNCT7_b5   = f7b5_q;
    assign valid_out   = valid_q;
    assign ILLEGAL_out = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with hand-computed expectations for
// decode_stage. Inputs change 1 time unit after a rising edge; outputs are
// compared at that same point, after the edge has settled.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in_s;
    logic [31:0] ir_in_s;
    logic        valid_in_s;
    logic        stall_s;
    logic        flush_s;
    logic        wb_en_s;
    logic [4:0]  wb_rd_s;
    logic [31:0] wb_data_s;
    logic [31:0] pc_out_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic [31:0] imm_out_s;
    logic [4:0]  rd_out_s;
    logic [6:0]  opcode_out_s;
    logic [2:0]  funct3_out_s;
    logic        funct7_b5_s;
    logic        valid_out_s;
    logic        illegal_out_s;

    int n_total;
    int n_bad;

    decode_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PC_in      (pc_in_s),
        .IR_in      (ir_in_s),
        .valid_in   (valid_in_s),
        .stall      (stall_s),
        .flush      (flush_s),
        .WB_en      (wb_en_s),
        .WB_rd      (wb_rd_s),
        .WB_data    (wb_data_s),
        .PC_out     (pc_out_s),
        .RS1_val    (rs1_val_s),
        .RS2_val    (rs2_val_s),
        .IMM_out    (imm_out_s),
        .RD_out     (rd_out_s),
        .OPCODE_out (opcode_out_s),
        .FUNCT3_out (funct3_out_s),
        .FUNCT7_b5  (funct7_b5_s),
        .valid_out  (valid_out_s),
        .ILLEGAL_out(illegal_out_s)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] ir);
        pc_in_s    = pc;
        ir_in_s    = ir;
        valid_in_s = 1'b1;
    endtask

    task automatic check_bubble(input string tag);
        check_eq({tag, "_valid"},   {31'd0, valid_out_s},   32'd0);
        check_eq({tag, "_illegal"}, {31'd0, illegal_out_s}, 32'd0);
        check_eq({tag, "_rd"},      {27'd0, rd_out_s},      32'd0);
        check_eq({tag, "_pc"},      pc_out_s,               32'd0);
        check_eq({tag, "_imm"},     imm_out_s,              32'd0);
        check_eq({tag, "_rs1"},     rs1_val_s,              32'd0);
        check_eq({tag, "_op"},      {25'd0, opcode_out_s},  32'd0);
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        pc_in_s    = 32'h0000_0000;
        ir_in_s    = 32'h0000_0000;
        valid_in_s = 1'b0;
        stall_s    = 1'b0;
        flush_s    = 1'b0;
        wb_en_s    = 1'b0;
        wb_rd_s    = 5'd0;
        wb_data_s  = 32'h0000_0000;

        // 1: reset state, then addi x1,x0,5
        tick();
        tick();
        check_bubble("rst");
        rst_n = 1'b1;
        load(32'h0000_0100, 32'h0050_0093);
        tick();
        check_eq("addi_rd",    {27'd0, rd_out_s},     32'd1);
        check_eq("addi_imm",   imm_out_s,             32'd5);
        check_eq("addi_rs1",   rs1_val_s,             32'd0);
        check_eq("addi_op",    {25'd0, opcode_out_s}, 32'h13);
        check_eq("addi_valid", {31'd0, valid_out_s},  32'd1);
        check_eq("addi_pc",    pc_out_s,              32'h0000_0100);
        check_eq("addi_ill",   {31'd0, illegal_out_s},32'd0);

        // 2: write x2 with an invalid slot (bubble), then add x3,x2,x2
        valid_in_s = 1'b0;
        wb_en_s    = 1'b1;
        wb_rd_s    = 5'd2;
        wb_data_s  = 32'hDEAD_BEEF;
        tick();
        check_eq("inv_valid", {31'd0, valid_out_s}, 32'd0);
        check_eq("inv_rd",    {27'd0, rd_out_s},    32'd0);
        wb_en_s = 1'b0;
        load(32'h0000_0104, 32'h0021_01B3);
        tick();
        check_eq("add_rs1", rs1_val_s,              32'hDEAD_BEEF);
        check_eq("add_rs2", rs2_val_s,              32'hDEAD_BEEF);
        check_eq("add_rd",  {27'd0, rd_out_s},      32'd3);
        check_eq("add_ill", {31'd0, illegal_out_s}, 32'd0);
        check_eq("add_op",  {25'd0, opcode_out_s},  32'h33);
        check_eq("add_imm", imm_out_s,              32'd0);

        // 3: bypass on the load edge, then the write is visible from the array
        wb_en_s   = 1'b1;
        wb_rd_s   = 5'd2;
        wb_data_s = 32'h1234_5678;
        tick();
        check_eq("byp_rs1", rs1_val_s, 32'h1234_5678);
        check_eq("byp_rs2", rs2_val_s, 32'h1234_5678);
        wb_en_s = 1'b0;
        tick();
        check_eq("rf_rs1", rs1_val_s, 32'h1234_5678);

        // 4: immediates of every format and an illegal opcode
        load(32'h0000_0108, 32'hFE00_0EE3);   // beq x0,x0,-4
        tick();
        check_eq("b_imm", imm_out_s,              32'hFFFF_FFFC);
        check_eq("b_ill", {31'd0, illegal_out_s}, 32'd0);
        load(32'h0000_010C, 32'hFE20_2E23);   // sw x2,-4(x0)
        tick();
        check_eq("s_imm", imm_out_s,             32'hFFFF_FFFC);
        check_eq("s_rs2", rs2_val_s,             32'h1234_5678);
        check_eq("s_f3",  {29'd0, funct3_out_s}, 32'd2);
        load(32'h0000_0110, 32'hABCD_E2B7);   // lui x5,0xABCDE
        tick();
        check_eq("u_imm", imm_out_s,         32'hABCD_E000);
        check_eq("u_rd",  {27'd0, rd_out_s}, 32'd5);
        load(32'h0000_0114, 32'h0080_00EF);   // jal x1,8
        tick();
        check_eq("j_imm", imm_out_s, 32'd8);
        load(32'h0000_0118, 32'hFFF0_0093);   // addi x1,x0,-1
        tick();
        check_eq("i_neg_imm", imm_out_s, 32'hFFFF_FFFF);
        load(32'h0000_011C, 32'h4020_81B3);   // sub x3,x1,x2
        tick();
        check_eq("sub_f7b5", {31'd0, funct7_b5_s}, 32'd1);
        check_eq("sub_rs1",  rs1_val_s,            32'd0);
        load(32'h0000_0120, 32'h0000_0000);
        tick();
        check_eq("zero_ill",   {31'd0, illegal_out_s}, 32'd1);
        check_eq("zero_valid", {31'd0, valid_out_s},   32'd1);

        // 5: stall holds for 3 edges while IR changes; RF write still lands
        load(32'h0000_0200, 32'h0050_0093);
        tick();
        stall_s = 1'b1;
        load(32'h0000_0204, 32'h0021_01B3);
        wb_en_s   = 1'b1;
        wb_rd_s   = 5'd1;
        wb_data_s = 32'hAAAA_5555;
        for (int k = 0; k < 3; k++) begin
            tick();
            wb_en_s = 1'b0;
            ir_in_s = ir_in_s + 32'h0000_1000;
            check_eq("stall_pc",    pc_out_s,             32'h0000_0200);
            check_eq("stall_rd",    {27'd0, rd_out_s},    32'd1);
            check_eq("stall_imm",   imm_out_s,            32'd5);
            check_eq("stall_valid", {31'd0, valid_out_s}, 32'd1);
        end
        flush_s = 1'b1;
        tick();
        check_bubble("stflush");
        stall_s = 1'b0;
        flush_s = 1'b0;
        load(32'h0000_0208, 32'h4020_81B3);   // sub x3,x1,x2
        tick();
        check_eq("stall_wb_rs1", rs1_val_s, 32'hAAAA_5555);
        check_eq("stall_wb_rs2", rs2_val_s, 32'h1234_5678);

        // 6: x0 stays zero, including a same-edge write to x0
        wb_en_s   = 1'b1;
        wb_rd_s   = 5'd0;
        wb_data_s = 32'hFFFF_FFFF;
        tick();
        load(32'h0000_020C, 32'h0000_00B3);   // add x1,x0,x0
        tick();
        check_eq("x0_rs1", rs1_val_s, 32'd0);
        check_eq("x0_rs2", rs2_val_s, 32'd0);
        wb_en_s = 1'b0;
        tick();
        check_eq("x0_rs1_b", rs1_val_s, 32'd0);

        // mid-run reset clears outputs immediately and empties the RF
        load(32'h0000_0300, 32'h0050_0093);
        tick();
        check_eq("pre_rst_valid", {31'd0, valid_out_s}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_bubble("midrst");
        #1;
        rst_n = 1'b1;
        load(32'h0000_0304, 32'h4020_81B3);   // sub x3,x1,x2
        tick();
        check_eq("post_rst_rs1", rs1_val_s, 32'd0);
        check_eq("post_rst_rs2", rs2_val_s, 32'd0);
        check_eq("post_rst_valid", {31'd0, valid_out_s}, 32'd1);

        // flush alone bubbles a valid load
        flush_s = 1'b1;
        tick();
        check_bubble("flush");
        flush_s = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
